// File: rtl/regfile_write_port.sv
// Write side of the dual-issue 32x32 register file with a busy scoreboard.
// Optional macro RF_WB_BYPASS_EN makes regs_flat/busy show this cycle's updates combinationally.
module regfile_write_port #(
    parameter int NREG = 32,
    parameter int DW   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wb0_en,
    input  logic [4:0]           wb0_addr,
    input  logic [DW-1:0]        wb0_data,
    input  logic                 wb1_en,
    input  logic [4:0]           wb1_addr,
    input  logic [DW-1:0]        wb1_data,
    input  logic                 iss0_en,
    input  logic [4:0]           iss0_addr,
    input  logic                 iss1_en,
    input  logic [4:0]           iss1_addr,
    output logic [NREG*DW-1:0]   regs_flat,
    output logic [NREG-1:0]      busy,
    output logic [15:0]          wr_count
);
    localparam int AW = 5;

    logic [DW-1:0]   regs_q [NREG];
    logic [DW-1:0]   regs_d [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [15:0]     wr_count_q;
    logic [15:0]     wr_count_d;
    logic            wb0_hit_s;
    logic            wb1_hit_s;
    logic [1:0]      wr_num_s;
    logic [16:0]     wr_sum_s;

    // Next-state register contents; lane 1 overrides lane 0 on a shared address.
    always_comb begin
        wb0_hit_s = wb0_en && (wb0_addr != 5'd0);
        wb1_hit_s = wb1_en && (wb1_addr != 5'd0);
        regs_d[0] = {DW{1'b0}};
        for (int i = 1; i < NREG; i++) begin
            if (wb1_hit_s && (wb1_addr == AW'(i))) begin
                regs_d[i] = wb1_data;
            end else if (wb0_hit_s && (wb0_addr == AW'(i))) begin
                regs_d[i] = wb0_data;
            end else begin
                regs_d[i] = regs_q[i];
            end
        end
    end

    // Scoreboard next state: clears applied first so a same-cycle issue keeps the bit set.
    always_comb begin
        busy_d = busy_q;
        for (int i = 1; i < NREG; i++) begin
            if ((wb0_en && (wb0_addr == AW'(i))) || (wb1_en && (wb1_addr == AW'(i)))) begin
                busy_d[i] = 1'b0;
            end else begin
                busy_d[i] = busy_q[i];
            end
            if ((iss0_en && (iss0_addr == AW'(i))) || (iss1_en && (iss1_addr == AW'(i)))) begin
                busy_d[i] = 1'b1;
            end else begin
                busy_d[i] = busy_d[i];
            end
        end
        busy_d[0] = 1'b0;
    end

    // Saturating write counter; a same-address collision commits only one write.
    always_comb begin
        if (wb0_hit_s && wb1_hit_s && (wb0_addr == wb1_addr)) begin
            wr_num_s = 2'd1;
        end else begin
            wr_num_s = {1'b0, wb0_hit_s} + {1'b0, wb1_hit_s};
        end
        wr_sum_s = {1'b0, wr_count_q} + {15'd0, wr_num_s};
        if (wr_sum_s[16]) begin
            wr_count_d = 16'hFFFF;
        end else begin
            wr_count_d = wr_sum_s[15:0];
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= {DW{1'b0}};
            end
            busy_q     <= {NREG{1'b0}};
            wr_count_q <= 16'd0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
            busy_q     <= busy_d;
            wr_count_q <= wr_count_d;
        end
    end

    // Output view: registered state, or the post-update state when bypassing.
    always_comb begin
        regs_flat = {(NREG*DW){1'b0}};
        busy      = {NREG{1'b0}};
`ifdef RF_WB_BYPASS_EN
        if (rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_flat[i*DW +: DW] = regs_d[i];
            end
            busy = busy_d;
        end else begin
            regs_flat = {(NREG*DW){1'b0}};
            busy      = {NREG{1'b0}};
        end
`else
        for (int i = 0; i < NREG; i++) begin
            regs_flat[i*DW +: DW] = regs_q[i];
        end
        busy = busy_q;
`endif
        wr_count = wr_count_q;
    end

endmodule

// File: tb/tb_regfile_write_port.sv
// Scoreboard bench for regfile_write_port: randomized and directed writeback/issue traffic.
module tb_regfile_write_port;
    logic          clk;
    logic          rst_n;
    logic          wb0_en, wb1_en, iss0_en, iss1_en;
    logic [4:0]    wb0_addr, wb1_addr, iss0_addr, iss1_addr;
    logic [31:0]   wb0_data, wb1_data;
    logic [1023:0] regs_flat;
    logic [31:0]   busy;
    logic [15:0]   wr_count;

    typedef struct {
        logic [1023:0] flat;
        logic [31:0]   bsy;
        logic [15:0]   cnt;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] m_regs [32];
    logic [31:0] m_busy;
    int          m_cnt;
    int          vectors;
    int          errors;

    regfile_write_port dut (
        .clk(clk), .rst_n(rst_n),
        .wb0_en(wb0_en), .wb0_addr(wb0_addr), .wb0_data(wb0_data),
        .wb1_en(wb1_en), .wb1_addr(wb1_addr), .wb1_data(wb1_data),
        .iss0_en(iss0_en), .iss0_addr(iss0_addr),
        .iss1_en(iss1_en), .iss1_addr(iss1_addr),
        .regs_flat(regs_flat), .busy(busy), .wr_count(wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [1023:0] act, input logic [1023:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t model_snapshot();
        exp_t e;
        for (int i = 0; i < 32; i++) e.flat[i*32 +: 32] = m_regs[i];
        e.bsy = m_busy;
        e.cnt = 16'(m_cnt);
        return e;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_busy = 32'd0;
        m_cnt  = 0;
    endtask

    // Apply one cycle of inputs at the falling edge and queue the state expected after the next rising edge.
    task automatic drive(input logic w0e, input logic [4:0] w0a, input logic [31:0] w0d,
                         input logic w1e, input logic [4:0] w1a, input logic [31:0] w1d,
                         input logic i0e, input logic [4:0] i0a,
                         input logic i1e, input logic [4:0] i1a);
        exp_t e;
        int   n;
        @(negedge clk);
        wb0_en = w0e; wb0_addr = w0a; wb0_data = w0d;
        wb1_en = w1e; wb1_addr = w1a; wb1_data = w1d;
        iss0_en = i0e; iss0_addr = i0a; iss1_en = i1e; iss1_addr = i1a;
        n = 0;
        if (w0e && w0a != 5'd0) begin
            m_regs[w0a] = w0d;
            n = n + 1;
        end
        if (w1e && w1a != 5'd0) begin
            m_regs[w1a] = w1d;
            if (!(w0e && w0a == w1a)) n = n + 1;
        end
        m_cnt = (m_cnt + n > 65535) ? 65535 : m_cnt + n;
        if (w0e) m_busy[w0a] = 1'b0;
        if (w1e) m_busy[w1a] = 1'b0;
        if (i0e) m_busy[i0a] = 1'b1;
        if (i1e) m_busy[i1a] = 1'b1;
        m_busy[0] = 1'b0;
        e = model_snapshot();
        exp_q.push_back(e);
`ifdef RF_WB_BYPASS_EN
        #1;
        chk("bypass_regs", regs_flat, e.flat);
        chk("bypass_busy", {992'd0, busy}, {992'd0, e.bsy});
`endif
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: one registered result per rising edge, compared against the oldest queued expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst_n && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("regs_flat", regs_flat, e.flat);
            chk("busy", {992'd0, busy}, {992'd0, e.bsy});
            chk("wr_count", {1008'd0, wr_count}, {1008'd0, e.cnt});
        end
    end

    initial begin
        logic [4:0] a0, a1;
        vectors = 0;
        errors  = 0;
        model_clear();
        rst_n = 1'b0;
        wb0_en = 1'b0; wb0_addr = 5'd0; wb0_data = 32'd0;
        wb1_en = 1'b0; wb1_addr = 5'd0; wb1_data = 32'd0;
        iss0_en = 1'b0; iss0_addr = 5'd0; iss1_en = 1'b0; iss1_addr = 5'd0;
        #12;
        chk("reset_regs", regs_flat, 1024'd0);
        chk("reset_busy", {992'd0, busy}, 1024'd0);
        chk("reset_count", {1008'd0, wr_count}, 1024'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic, addresses biased low so collisions and set/clear overlaps happen.
        for (int k = 0; k < 400; k++) begin
            a0 = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            a1 = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            drive(1'($urandom_range(0, 1)), a0, $urandom,
                  1'($urandom_range(0, 1)), a1, $urandom,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
        end

        // Mid-cycle asynchronous reset while writes are presented.
        @(negedge clk);
        wb0_en = 1'b1; wb0_addr = 5'd6; wb0_data = 32'hCAFE0001;
        wb1_en = 1'b1; wb1_addr = 5'd11; wb1_data = 32'hCAFE0002;
        iss0_en = 1'b1; iss0_addr = 5'd12; iss1_en = 1'b0; iss1_addr = 5'd0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_regs", regs_flat, 1024'd0);
        chk("async_rst_busy", {992'd0, busy}, 1024'd0);
        chk("async_rst_count", {1008'd0, wr_count}, 1024'd0);
        exp_q.delete();
        model_clear();
        @(negedge clk);
        wb0_en = 1'b0; wb1_en = 1'b0; iss0_en = 1'b0;
        rst_n = 1'b1;

        // Dual write to distinct registers.
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd9, 32'h12345678, 1'b0, 5'd0, 1'b0, 5'd0);
        settle();
        chk("dual_r5", {992'd0, regs_flat[191:160]}, {992'd0, 32'hDEADBEEF});
        chk("dual_r9", {992'd0, regs_flat[319:288]}, {992'd0, 32'h12345678});
        chk("dual_count", {1008'd0, wr_count}, {1008'd0, 16'd2});

        // Same-address collision: lane 1 wins, counted once.
        drive(1'b1, 5'd7, 32'h1, 1'b1, 5'd7, 32'h2, 1'b0, 5'd0, 1'b0, 5'd0);
        settle();
        chk("collide_r7", {992'd0, regs_flat[255:224]}, {992'd0, 32'h2});
        chk("collide_count", {1008'd0, wr_count}, {1008'd0, 16'd3});

        // Register zero ignores writes and issue claims.
        drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 1'b0, 5'd0);
        settle();
        chk("zero_r0", {992'd0, regs_flat[31:0]}, 1024'd0);
        chk("zero_busy0", {1023'd0, busy[0]}, 1024'd0);
        chk("zero_count", {1008'd0, wr_count}, {1008'd0, 16'd3});

        // Scoreboard set, set-beats-clear, then clear.
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 1'b0, 5'd0);
        settle();
        chk("sb_set", {1023'd0, busy[3]}, {1023'd0, 1'b1});
        drive(1'b1, 5'd3, 32'hA, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 5'd3);
        settle();
        chk("sb_set_wins", {1023'd0, busy[3]}, {1023'd0, 1'b1});
        chk("sb_r3", {992'd0, regs_flat[127:96]}, {992'd0, 32'hA});
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'hB, 1'b0, 5'd0, 1'b0, 5'd0);
        settle();
        chk("sb_clear", {1023'd0, busy[3]}, 1024'd0);

`ifdef RF_WB_BYPASS_EN
        @(negedge clk);
        wb0_en = 1'b1; wb0_addr = 5'd4; wb0_data = 32'h55;
        #1;
        chk("bypass_r4", {992'd0, regs_flat[159:128]}, {992'd0, 32'h55});
        wb0_en = 1'b0;
`endif

        // Preload the counter to 16'hFFFE, then saturate.
        while (m_cnt < 65534) begin
            if (65534 - m_cnt >= 2)
                drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 1'b0, 5'd0, 1'b0, 5'd0);
            else
                drive(1'b1, 5'd1, 32'h11, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        end
        settle();
        chk("preload_count", {1008'd0, wr_count}, {1008'd0, 16'hFFFE});
        drive(1'b1, 5'd13, 32'h13, 1'b1, 5'd14, 32'h14, 1'b0, 5'd0, 1'b0, 5'd0);
        settle();
        chk("sat_count", {1008'd0, wr_count}, {1008'd0, 16'hFFFF});
        drive(1'b1, 5'd15, 32'h15, 1'b1, 5'd16, 32'h16, 1'b0, 5'd0, 1'b0, 5'd0);
        settle();
        chk("sat_hold", {1008'd0, wr_count}, {1008'd0, 16'hFFFF});

        idle();
        idle();
        settle();
        chk("queue_drained", 1024'(exp_q.size()), 1024'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/regfile_write_port.md
Name: regfile_write_port

Overview:
- Write side of the 32x32 integer register file for the dual-issue MIPS pipeline.
- Accepts up to two writeback lanes per cycle and holds the 32 architectural registers.
- Drives the full register contents as a flat bus that the 32-to-1 read muxes select from.
- Includes a busy scoreboard: issue marks a destination pending; writeback clears it.

Parameters:
- NREG, 32, number of architectural registers (fixed at 32; address width 5).
- DW, 32, data width per register.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- wb0_en  in  1  lane-0 (older instruction) writeback valid.
- wb0_addr  in  5  lane-0 destination register.
- wb0_data  in  32  lane-0 write data.
- wb1_en  in  1  lane-1 (younger instruction) writeback valid.
- wb1_addr  in  5  lane-1 destination register.
- wb1_data  in  32  lane-1 write data.
- iss0_en  in  1  issue lane 0 claims a destination.
- iss0_addr  in  5  lane-0 claimed register.
- iss1_en  in  1  issue lane 1 claims a destination.
- iss1_addr  in  5  lane-1 claimed register.
- regs_flat  out  1024  register i on bits [32*i+31 : 32*i].
- busy  out  32  bit i=1 means register i has an outstanding write.
- wr_count  out  16  saturating count of committed register writes, for debug.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All 32 registers = 0; busy = 0; wr_count = 0.
  - Takes effect immediately, including mid-cycle and during any write.
- Register writes:
  - Committed on the rising clk edge; new value visible on regs_flat the following cycle (latency 1).
  - Writes to address 0 are discarded; register 0 always reads 0; never marked busy.
  - Both lanes to different nonzero addresses: both written in the same cycle.
  - Both lanes to the same nonzero address: lane 1 data wins (program order).
- Scoreboard, evaluated at each clock edge:
  - Set: iss0_en/iss1_en set busy[addr] for addr != 0.
  - Clear: wb0_en/wb1_en clear busy[addr].
  - Set and clear to the same register in one cycle: set wins (a new producer was issued).
  - Both issue lanes to the same address: single set.
  - Busy bits are registered; updated value visible the cycle after the edge.
  - Writeback to a non-busy register: still written; busy stays 0; no error.
- wr_count:
  - Increments by the number of lanes that actually write a nonzero register (0, 1 or 2).
  - A same-address collision counts as 1.
  - Saturates at 16'hFFFF; no wrap.
- No stall or handshake: the block always accepts both lanes every cycle. Hazard avoidance is upstream's job, using busy.

Optional Feature:
- Macro: RF_WB_BYPASS_EN.
- Defined:
  - regs_flat is combinational: for each register written this cycle, it shows the incoming writeback data (lane 1 priority).
  - busy shows the post-update value.
  - Effective latency 0; same-cycle read-after-write needs no extra stall.
  - Register 0 still reads 0.
- Undefined: purely registered outputs, latency 1 as above.

Test Plan:
- Reset: drive random writes, pulse rst_n low mid-cycle -> regs_flat=0, busy=0, wr_count=0 immediately, before the next clk edge.
- Dual write: wb0 r5=32'hDEADBEEF, wb1 r9=32'h12345678, same cycle -> next cycle r5 and r9 hold those values; wr_count=2.
- Collision: wb0 r7=32'h1, wb1 r7=32'h2 -> r7=32'h2; wr_count increments by 1.
- Zero register: wb0 r0=32'hFFFFFFFF with iss0 r0 -> r0 stays 0; busy[0]=0; wr_count unchanged.
- Scoreboard: iss0 r3 -> busy[3]=1 next cycle. Later, same cycle iss1 r3 and wb0 r3=32'hA -> busy[3] stays 1 and r3=32'hA. Then wb1 r3 alone -> busy[3]=0.
- Saturation, plus bypass when RF_WB_BYPASS_EN is defined: preload wr_count to 16'hFFFE via writes, then dual write -> wr_count=16'hFFFF and stays there. With the macro defined, wb0 r4=32'h55 -> regs_flat[159:128]=32'h55 in the same cycle.
